stump_reg_dump: RTL
===================

# stump_reg_dump

Debug read-out engine for the Stump processor state. On request it halts the core and reads the eight 16-bit registers through the register-bank read port. It also samples the 4-bit condition-code register output. It streams the snapshot as a framed byte sequence over a valid/ready byte interface to the board debug link.

## Interface
Parameters:
- HEADER, 8'hA5, first byte of every frame

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST  input  1  reset, synchronous and active-high
- start  input  1  dump request, sampled only in IDLE
- halt_req  output  1  freezes the processor while high
- reg_sel  output  3  register-bank read address
- reg_data  input  16  register-bank read data for reg_sel, combinational, same cycle
- cc  input  4  condition-code register value {N,Z,V,C}
- tx_byte  output  8  byte being offered
- tx_valid  output  1  tx_byte valid
- tx_ready  input  1  sink accepts tx_byte when high with tx_valid
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse after the last byte is accepted

## Operation
- Frame is 19 bytes, in this order:
  - HEADER
  - R0 hi, R0 lo, R1 hi, R1 lo, …, R7 hi, R7 lo
  - {4'h0, cc}
  - checksum
- Checksum is the XOR of all 18 preceding bytes, including HEADER.
- States: IDLE, HDR, HI, LO, CC, SUM. All outputs are registered.
- 4-bit index counter idx; reg_sel = idx[2:0].
- IDLE:
  - busy, halt_req and tx_valid are 0; idx=0.
  - start=1: load tx_byte=HEADER and sum=HEADER; set tx_valid, busy, halt_req; go to HDR.
- A handshake is tx_valid & tx_ready at a rising edge. On a handshake the next byte is loaded on that same edge, and tx_valid stays 1 (back-to-back transfers).
- Without a handshake, tx_byte, state, idx and sum hold.
- Handshake in HDR or LO with idx<8:
  - Load tx_byte=reg_data[15:8].
  - Latch reg_data[7:0] into a low-byte hold register; this makes the word atomic.
  - idx <= idx+1; go to HI.
- Handshake in HI: load tx_byte = hold; go to LO.
- Handshake in LO with idx==8: load tx_byte={4'h0,cc} (cc sampled on this edge); go to CC.
- Handshake in CC: load tx_byte = sum, with the CC byte already folded in; go to SUM.
- sum ^= each loaded byte except the checksum itself.
- Handshake in SUM:
  - Go to IDLE; tx_valid, busy and halt_req drop to 0.
  - done=1 for exactly the next cycle.
- start while busy is ignored. start in the cycle done is high is accepted normally.
- reg_data and cc are sampled only on their capture edges. Later changes do not affect bytes already loaded.

## Timing
- Reset value of every output is 0: halt_req, reg_sel, tx_byte, tx_valid, busy, done. Internal idx, sum, hold and state also reset (state to IDLE).
- RST=1 at any point, including mid-frame, forces IDLE on that edge.
  - The partial frame is abandoned; no done pulse; halt_req is released.
  - RST has priority over start and over handshakes.
- Latency: start sampled at edge E0 → tx_valid=1, halt_req=1, tx_byte=HEADER from E0.
- With tx_ready held 1, handshakes occur at E1..E19 and done=1 in the cycle following E19.
- The first register read (R0) occurs at E1 or later, at least one full cycle after halt_req rises.
- Back-pressure: any number of tx_ready=0 cycles is legal. tx_byte must stay stable and tx_valid stay 1 throughout a stall.
- tx_valid never drops mid-frame except on RST.

## Test plan
- Reset:
  - Stimulus: RST=1 for 2 cycles, then start=0.
  - Required: all outputs 0, reg_sel=0, no done.
- Full dump, no back-pressure:
  - Stimulus: Rk=16'h1111*k, cc=4'b1010, tx_ready=1, start pulse.
  - Required stream: A5 00 00 11 11 22 22 … 77 77 0A AF.
  - Required: done exactly one cycle after the 19th handshake; halt_req high throughout the frame.
- Back-pressure:
  - Stimulus: tx_ready alternating 1/0, plus a 5-cycle stall on the R3 lo byte.
  - Required: identical byte stream; tx_byte stable during every stall; frame completes in 19 handshakes.
- Atomic capture:
  - Stimulus: change R2 low byte from 22 to 99 in the cycle after R2 hi is accepted; change cc after the CC byte loads.
  - Required: R2 lo byte = 22; CC byte and checksum unchanged from the original values.
- Reset mid-frame:
  - Stimulus: assert RST at the handshake of R5 hi.
  - Required: tx_valid, busy and halt_req are 0 on the following cycle; no done.
  - Then: a subsequent start yields a complete frame beginning with A5.
- Start collisions:
  - Stimulus: start held high for the whole frame.
  - Required: no restart mid-frame; a new frame begins in the done cycle, with HEADER loaded at that edge.

Source files
------------

// File: rtl/stump_reg_dump.sv
// stump_reg_dump
// Debug read-out engine for the Stump processor. A start request halts the
// core, walks the eight 16-bit registers through the register-bank read
// port, samples the condition codes and streams a 19-byte frame:
//   HEADER, R0 hi, R0 lo, ... R7 hi, R7 lo, {4'h0,cc}, XOR checksum
//
// Ports:
//   CLK       system clock, rising edge
//   RST       synchronous active-high reset
//   start     dump request, honoured only when idle
//   halt_req  processor freeze, high for the whole frame
//   reg_sel   register-bank read address
//   reg_data  register-bank read data (combinational from reg_sel)
//   cc        condition codes {N,Z,V,C}
//   tx_byte   byte offered to the debug link
//   tx_valid  tx_byte valid
//   tx_ready  sink accepts tx_byte when high together with tx_valid
//   busy      frame in progress
//   done      one-cycle pulse after the final byte is accepted
//
// state | meaning
// IDLE  | waiting for start, nothing offered
// HDR   | offering HEADER
// HI    | offering high byte of register idx-1
// LO    | offering low byte of register idx-1 (from the hold register)
// CC    | offering the condition-code byte
// SUM   | offering the checksum
module stump_reg_dump #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output logic        halt_req,
  output logic [2:0]  reg_sel,
  input  logic [15:0] reg_data,
  input  logic [3:0]  cc,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    CC   = 3'd4,
    SUM  = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [7:0]  sum, sum_n;
  logic [7:0]  hold, hold_n;
  logic [7:0]  tx_byte_n;
  logic        tx_valid_n, busy_n, halt_n, done_n;
  logic        hs;
  logic [7:0]  cc_byte;

  assign hs      = tx_valid & tx_ready;
  assign cc_byte = {4'h0, cc};
  assign reg_sel = idx[2:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= 4'd0;
      sum      <= 8'd0;
      hold     <= 8'd0;
      tx_byte  <= 8'd0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      halt_req <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      sum      <= sum_n;
      hold     <= hold_n;
      tx_byte  <= tx_byte_n;
      tx_valid <= tx_valid_n;
      busy     <= busy_n;
      halt_req <= halt_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    sum_n      = sum;
    hold_n     = hold;
    tx_byte_n  = tx_byte;
    tx_valid_n = tx_valid;
    busy_n     = busy;
    halt_n     = halt_req;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        idx_n      = 4'd0;
        tx_valid_n = 1'b0;
        busy_n     = 1'b0;
        halt_n     = 1'b0;
        if (start) begin
          tx_byte_n  = HEADER;
          sum_n      = HEADER;
          tx_valid_n = 1'b1;
          busy_n     = 1'b1;
          halt_n     = 1'b1;
          state_n    = HDR;
        end
      end
      HDR, LO: begin
        if (hs) begin
          if (idx < 4'd8) begin
            // Low byte is captured together with the high byte so the
            // streamed word is a single coherent read.
            tx_byte_n = reg_data[15:8];
            hold_n    = reg_data[7:0];
            sum_n     = sum ^ reg_data[15:8];
            idx_n     = idx + 4'd1;
            state_n   = HI;
          end else begin
            tx_byte_n = cc_byte;
            sum_n     = sum ^ cc_byte;
            state_n   = CC;
          end
        end
      end
      HI: begin
        if (hs) begin
          tx_byte_n = hold;
          sum_n     = sum ^ hold;
          state_n   = LO;
        end
      end
      CC: begin
        if (hs) begin
          tx_byte_n = sum;
          state_n   = SUM;
        end
      end
      SUM: begin
        if (hs) begin
          tx_valid_n = 1'b0;
          busy_n     = 1'b0;
          halt_n     = 1'b0;
          done_n     = 1'b1;
          idx_n      = 4'd0;
          state_n    = IDLE;
        end
      end
      default: begin
        state_n    = IDLE;
        tx_valid_n = 1'b0;
        busy_n     = 1'b0;
        halt_n     = 1'b0;
      end
    endcase
  end

endmodule
